integrated_datapath: RTL and testbench

INTEGRATED_DATAPATH -- requirements
Module: integrated_datapath

---
 rtl/integrated_datapath_pkg.sv | 54 +++++
 rtl/integrated_datapath_control_unit.sv | 73 +++++++
 rtl/integrated_datapath.sv | 134 +++++++++++++
 tb/tb_integrated_datapath.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/integrated_datapath_pkg.sv
// Shared definitions for the multicycle 16-bit processor:
// opcodes, FSM state encodings, register names and sign-extension helpers.
package integrated_datapath_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLT  = 4'h5,
        OP_ADDI = 4'h6,
        OP_LUI  = 4'h7,
        OP_ORI  = 4'h8,
        OP_LW   = 4'h9,
        OP_SW   = 4'hA,
        OP_BEQ  = 4'hB,
        OP_BNE  = 4'hC,
        OP_JAL  = 4'hD,
        OP_JR   = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [4:0] {
        S_FETCH     = 5'd0,
        S_DECODE    = 5'd1,
        S_EXEC      = 5'd2,
        S_MEM_ADDR  = 5'd3,
        S_MEM_READ  = 5'd4,
        S_MEM_WRITE = 5'd5,
        S_WB        = 5'd6,
        S_BRANCH    = 5'd7,
        S_JUMP      = 5'd8,
        S_HALT      = 5'd9
    } state_e;

    typedef enum logic [3:0] {
        R_ZERO = 4'd0,  R_SP   = 4'd1,  R_T0   = 4'd2,  R_T1   = 4'd3,
        R_T2   = 4'd4,  R_RA   = 4'd5,  R_S0   = 4'd6,  R_S1   = 4'd7,
        R_S2   = 4'd8,  R_RV0  = 4'd9,  R_RV1  = 4'd10, R_ARG0 = 4'd11,
        R_ARG1 = 4'd12, R_G13  = 4'd13, R_G14  = 4'd14, R_G15  = 4'd15
    } reg_idx_e;

    localparam logic [15:0] SP_RESET = 16'h0FFF;

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/integrated_datapath_control_unit.sv
// Instruction-sequencing FSM plus the free-running cycle and retired-instruction counters.
module control_unit
    import integrated_datapath_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  opcode_e     op_i,        // opcode held in the instruction register
    input  opcode_e     fetch_op_i,  // opcode of the word currently addressed by pc
    output state_e      state_o,
    output logic [31:0] cycle_count_o,
    output logic [31:0] instruction_count_o
);

    state_e      state_q, state_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instr_q, instr_d;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:     state_d = (fetch_op_i == OP_HALT) ? S_HALT : S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
                    OP_ADDI, OP_LUI, OP_ORI: state_d = S_EXEC;
                    OP_LW, OP_SW:            state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:          state_d = S_BRANCH;
                    OP_JAL, OP_JR:           state_d = S_JUMP;
                    default:                 state_d = S_HALT;
                endcase
            end
            S_EXEC:      state_d = S_WB;
            S_MEM_ADDR:  state_d = (op_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = S_WB;
            S_MEM_WRITE: state_d = S_FETCH;
            S_WB:        state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    // HALT is recognised during its own fetch, and that fetch cycle is not billed,
    // so cycle_count at HALT entry equals the cycles of the instructions before it.
    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        if (state_d != S_HALT) cycle_d = cycle_q + 32'd1;
        if ((state_d == S_FETCH && state_q != S_FETCH) ||
            (state_d == S_HALT  && state_q != S_HALT))
            instr_d = instr_q + 32'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign state_o             = state_q;
    assign cycle_count_o       = cycle_q;
    assign instruction_count_o = instr_q;

endmodule

// File: rtl/integrated_datapath.sv
// Multicycle 16-bit processor datapath: pc, IR, register file, ALU and unified 4K x 16 memory.
// Memory contents are preloaded from outside (program image) and survive reset.
module integrated_datapath
    import integrated_datapath_pkg::*;
(
    input logic Clock,
    input logic Reset
);

    logic [15:0] mem  [0:4095];
    logic [15:0] regs [0:15];

    logic [15:0] pc, instruction;
    logic [15:0] a_q, b_q, alu_q, mdr_q;
    logic [31:0] cycle_count, instruction_count;
    logic [4:0]  current_state;
    state_e      state;

    opcode_e     op;
    logic [3:0]  rd, rs, rt;
    logic [7:0]  imm8;
    logic [11:0] imm12;
    logic [15:0] fetch_word;

    assign op         = opcode_e'(instruction[15:12]);
    assign rd         = instruction[11:8];
    assign rs         = instruction[7:4];
    assign rt         = instruction[3:0];
    assign imm8       = instruction[7:0];
    assign imm12      = instruction[11:0];
    assign fetch_word = mem[pc[11:0]];

    control_unit u_ctrl (
        .clk_i               (Clock),
        .rst_ni              (Reset),
        .op_i                (op),
        .fetch_op_i          (opcode_e'(fetch_word[15:12])),
        .state_o             (state),
        .cycle_count_o       (cycle_count),
        .instruction_count_o (instruction_count)
    );

    assign current_state = state;

    // Operand A is the base/first source; branches, immediates and JR operate on rd.
    logic [3:0] a_idx, b_idx;
    always_comb begin
        a_idx = rd;
        b_idx = rt;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_LW: a_idx = rs;
            OP_SW:          begin a_idx = rs; b_idx = rd; end
            OP_BEQ, OP_BNE: b_idx = rs;
            default: ;
        endcase
    end

    logic [15:0] alu_res;
    always_comb begin
        alu_res = a_q + sext4(rt);
        case (op)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SLT:  alu_res = {15'd0, $signed(a_q) < $signed(b_q)};
            OP_ADDI: alu_res = a_q + sext8(imm8);
            OP_LUI:  alu_res = {imm8, 8'h00};
            OP_ORI:  alu_res = a_q | {8'h00, imm8};
            default: ;
        endcase
    end

    logic        branch_taken;
    assign branch_taken = (a_q == b_q) ^ (op == OP_BNE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc          <= '0;
            instruction <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    instruction <= fetch_word;
                    pc          <= pc + 16'd1;
                end
                S_DECODE: begin
                    a_q <= regs[a_idx];
                    b_q <= regs[b_idx];
                end
                S_EXEC, S_MEM_ADDR: alu_q <= alu_res;
                S_MEM_READ:         mdr_q <= mem[alu_q[11:0]];
                S_BRANCH: if (branch_taken) pc <= pc + sext4(rt);
                S_JUMP:   pc <= (op == OP_JAL) ? {pc[15:12], imm12} : a_q;
                default: ;
            endcase
        end
    end

    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
        if (state == S_WB) rf_we = 1'b1;
        if (state == S_JUMP && op == OP_JAL) begin
            rf_we    = 1'b1;
            rf_waddr = R_RA;
            rf_wdata = pc;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= (i == int'(R_SP)) ? SP_RESET : 16'h0000;
        end else if (rf_we && rf_waddr != R_ZERO) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // NOTE: memory has no reset branch; it holds the program image across reset.
    always_ff @(posedge Clock) begin
        if (state == S_MEM_WRITE) mem[alu_q[11:0]] <= b_q;
    end

endmodule

// File: tb/tb_integrated_datapath.sv
// Directed-program bench for integrated_datapath: loads small programs through the
// memory hierarchy, runs them, and compares architectural state to hand-computed values.
module tb_integrated_datapath;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 Clock = ~Clock;

    integrated_datapath dut (
        .Clock (Clock),
        .Reset (Reset)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int addr, input logic [15:0] w);
        dut.mem[addr] = w;
    endtask

    // Hold reset and clear the low program area and the top-of-stack region.
    task automatic begin_program();
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) poke(i, 16'h0000);
        for (int i = 'hFF0; i < 'h1000; i++) poke(i, 16'h0000);
    endtask

    task automatic release_reset();
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int k = 0;
        while (dut.current_state !== 5'd9 && k < budget) begin
            @(negedge Clock);
            k++;
        end
        check({tag, "_halted"}, 32'(dut.current_state), 32'd9);
    endtask

    initial begin
        // ADDI t0,5; ADDI t1,-3; ADD t2,t0,t1; HALT
        begin_program();
        poke(0, 16'h6205); poke(1, 16'h63FD); poke(2, 16'h0423); poke(3, 16'hF000);
        release_reset();
        check("rst_pc",    32'(dut.pc), 32'h0);
        check("rst_state", 32'(dut.current_state), 32'd0);
        check("rst_cycle", dut.cycle_count, 32'd0);
        check("rst_icnt",  dut.instruction_count, 32'd0);
        check("rst_sp",    32'(dut.regs[1]), 32'h0FFF);
        wait_halt("add", 100);
        check("add_t2",    32'(dut.regs[4]), 32'h0002);
        check("add_cycle", dut.cycle_count, 32'd12);
        check("add_icnt",  dut.instruction_count, 32'd4);
        check("add_pc",    32'(dut.pc), 32'h4);
        step(5);
        check("halt_cycle_hold", dut.cycle_count, 32'd12);
        check("halt_icnt_hold",  dut.instruction_count, 32'd4);
        check("halt_pc_hold",    32'(dut.pc), 32'h4);

        // ADDI t0,5; SW t0,-1(sp); LW s0,-1(sp); HALT
        begin_program();
        poke(0, 16'h6205); poke(1, 16'hA21F); poke(2, 16'h961F); poke(3, 16'hF000);
        poke('hFFE, 16'h1234);
        release_reset();
        step(8);
        check("sw_pc",    32'(dut.pc), 32'h2);
        check("sw_mem",   32'(dut.mem['hFFE]), 32'h0005);
        step(4);
        check("lw_wb_state", 32'(dut.current_state), 32'd6);
        check("lw_s0_pending", 32'(dut.regs[6]), 32'h0000);
        step(1);
        check("lw_s0",    32'(dut.regs[6]), 32'h0005);
        check("lw_state", 32'(dut.current_state), 32'd0);
        check("lw_cycle", dut.cycle_count, 32'd13);

        // Reset during MEM_WRITE must abort the pending store.
        begin_program();
        poke(0, 16'h6205); poke(1, 16'hA21F); poke(2, 16'hF000);
        poke('hFFE, 16'h1234);
        release_reset();
        step(7);
        check("abort_state_memwr", 32'(dut.current_state), 32'd5);
        Reset = 1'b0;
        #1;
        check("abort_pc",    32'(dut.pc), 32'h0);
        check("abort_state", 32'(dut.current_state), 32'd0);
        check("abort_cycle", dut.cycle_count, 32'd0);
        check("abort_icnt",  dut.instruction_count, 32'd0);
        check("abort_sp",    32'(dut.regs[1]), 32'h0FFF);
        check("abort_t0",    32'(dut.regs[2]), 32'h0000);
        step(2);
        check("abort_mem",   32'(dut.mem['hFFE]), 32'h1234);

        // ALU coverage: t0=5, t1=-3, then SLT/SUB/XOR/AND/OR
        begin_program();
        poke(0, 16'h6205); poke(1, 16'h63FD); poke(2, 16'h5432); poke(3, 16'h5D23);
        poke(4, 16'h1E23); poke(5, 16'h4F23); poke(6, 16'h2623); poke(7, 16'h3723);
        poke(8, 16'hF000);
        release_reset();
        wait_halt("alu", 200);
        check("slt_true",  32'(dut.regs[4]),  32'h0001);
        check("slt_false", 32'(dut.regs[13]), 32'h0000);
        check("sub",       32'(dut.regs[14]), 32'h0008);
        check("xor",       32'(dut.regs[15]), 32'hFFF8);
        check("and",       32'(dut.regs[6]),  32'h0005);
        check("or",        32'(dut.regs[7]),  32'hFFFD);

        // BEQ t0,t0,+2 at pc=3 (taken)
        begin_program();
        poke(0, 16'h6205); poke(3, 16'hB222); poke(6, 16'hF000);
        release_reset();
        step(12);
        check("beq_pc_before", 32'(dut.pc), 32'h3);
        step(3);
        check("beq_pc",    32'(dut.pc), 32'h6);
        check("beq_state", 32'(dut.current_state), 32'd0);

        // BNE t0,t0,+2 at pc=3 (not taken)
        begin_program();
        poke(0, 16'h6205); poke(3, 16'hC222); poke(6, 16'hF000);
        release_reset();
        step(15);
        check("bne_pc", 32'(dut.pc), 32'h4);

        // JAL 0x010 at pc=2; JR ra at 0x010
        begin_program();
        poke(2, 16'hD010); poke(3, 16'hF000); poke('h10, 16'hE500);
        release_reset();
        step(8);
        check("jal_pc_before", 32'(dut.pc), 32'h2);
        step(3);
        check("jal_pc", 32'(dut.pc), 32'h0010);
        check("jal_ra", 32'(dut.regs[5]), 32'h0003);
        step(3);
        check("jr_pc",  32'(dut.pc), 32'h0003);
        wait_halt("jr", 10);

        // LUI t0,0x80; ORI t0,0xFF; ADDI t0,1; ADD r0,t0,t0; HALT
        begin_program();
        poke(0, 16'h7280); poke(1, 16'h82FF); poke(2, 16'h6201); poke(3, 16'h0022);
        poke(4, 16'hF000);
        release_reset();
        step(4);
        check("lui_t0", 32'(dut.regs[2]), 32'h8000);
        wait_halt("lui", 100);
        check("ori_addi_t0", 32'(dut.regs[2]), 32'h8100);
        check("r0_zero",     32'(dut.regs[0]), 32'h0000);
        check("lui_cycle",   dut.cycle_count, 32'd16);
        check("lui_icnt",    dut.instruction_count, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
